// File: rtl/vlog_comment_strip.sv
// Streaming Verilog comment stripper: removes // and /* */ comments, keeps newlines,
// and leaves string literals and escaped identifiers untouched. One registered output stage.
module vlog_comment_strip (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        err_unterm,
   output logic [15:0] line_num
);

   localparam logic [2:0] ST_CODE     = 3'd0;
   localparam logic [2:0] ST_SLASH    = 3'd1;
   localparam logic [2:0] ST_LINE     = 3'd2;
   localparam logic [2:0] ST_BLK      = 3'd3;
   localparam logic [2:0] ST_BLK_STAR = 3'd4;
   localparam logic [2:0] ST_STR      = 3'd5;
   localparam logic [2:0] ST_STR_ESC  = 3'd6;
   localparam logic [2:0] ST_ESC_ID   = 3'd7;

   localparam logic [7:0] CH_SLASH = 8'h2F;
   localparam logic [7:0] CH_STAR  = 8'h2A;
   localparam logic [7:0] CH_DQ    = 8'h22;
   localparam logic [7:0] CH_BS    = 8'h5C;
   localparam logic [7:0] CH_NL    = 8'h0A;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_TAB   = 8'h09;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_FF    = 8'h0C;

   function automatic logic is_ws(input logic [7:0] c);
      return (c == CH_SP) || (c == CH_TAB) || (c == CH_NL) || (c == CH_CR) || (c == CH_FF);
   endfunction

   logic [2:0]  state_q, state_d, nxt_state_s;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   logic        err_unterm_q, err_unterm_d;
   logic [15:0] line_q, line_d;
   logic        can_out_s, flush_s, xfer_s, emit_s, unterm_s;
   logic [7:0]  emit_byte_s;

   // handshake: a non-comment byte after '/' is held while the '/' is flushed
   always_comb begin
      can_out_s = !out_valid_q || out_ready;
      flush_s   = (state_q == ST_SLASH) && in_valid && can_out_s &&
                  (in_data != CH_SLASH) && (in_data != CH_STAR);
      in_ready  = can_out_s && !flush_s;
      xfer_s    = in_valid && in_ready;
   end

   // per-state decode of the incoming byte
   always_comb begin
      nxt_state_s = state_q;
      emit_s      = 1'b0;
      emit_byte_s = in_data;
      unterm_s    = 1'b0;
      case (state_q)
         ST_CODE: begin
            if (in_data == CH_SLASH) begin
               if (in_last) emit_s = 1'b1;
               else         nxt_state_s = ST_SLASH;
            end else if (in_data == CH_DQ) begin
               nxt_state_s = ST_STR;
               emit_s      = 1'b1;
            end else if (in_data == CH_BS) begin
               nxt_state_s = ST_ESC_ID;
               emit_s      = 1'b1;
            end else begin
               emit_s = 1'b1;
            end
         end
         ST_SLASH: begin
            if (in_data == CH_SLASH) begin
               nxt_state_s = ST_LINE;
            end else if (in_data == CH_STAR) begin
               nxt_state_s = ST_BLK;
               emit_s      = 1'b1;
               emit_byte_s = CH_SP;
            end else begin
               nxt_state_s = ST_CODE;
            end
         end
         ST_LINE: begin
            if (in_data == CH_NL) begin
               nxt_state_s = ST_CODE;
               emit_s      = 1'b1;
            end else begin
               emit_s = 1'b0;
            end
         end
         ST_BLK: begin
            if (in_data == CH_STAR) begin
               nxt_state_s = ST_BLK_STAR;
            end else if (in_data == CH_NL) begin
               emit_s = 1'b1;
            end else begin
               emit_s = 1'b0;
            end
         end
         ST_BLK_STAR: begin
            if (in_data == CH_SLASH) begin
               nxt_state_s = ST_CODE;
            end else if (in_data == CH_STAR) begin
               nxt_state_s = ST_BLK_STAR;
            end else if (in_data == CH_NL) begin
               nxt_state_s = ST_BLK;
               emit_s      = 1'b1;
            end else begin
               nxt_state_s = ST_BLK;
            end
         end
         ST_STR: begin
            emit_s = 1'b1;
            if (in_data == CH_BS) begin
               nxt_state_s = ST_STR_ESC;
            end else if (in_data == CH_DQ) begin
               nxt_state_s = ST_CODE;
            end else if (in_data == CH_NL) begin
               nxt_state_s = ST_CODE;
               unterm_s    = 1'b1;
            end else begin
               nxt_state_s = ST_STR;
            end
         end
         ST_STR_ESC: begin
            emit_s      = 1'b1;
            nxt_state_s = ST_STR;
         end
         ST_ESC_ID: begin
            emit_s = 1'b1;
            if (is_ws(in_data)) nxt_state_s = ST_CODE;
            else                nxt_state_s = ST_ESC_ID;
         end
         default: begin
            nxt_state_s = ST_CODE;
         end
      endcase
      // a final byte always produces one output; a dropped one becomes a newline
      if (in_last) begin
         if (!emit_s) begin
            emit_s      = 1'b1;
            emit_byte_s = CH_NL;
         end else begin
            emit_s = 1'b1;
         end
         if ((state_q == ST_BLK) || ((state_q == ST_BLK_STAR) && (in_data != CH_SLASH))) begin
            unterm_s = 1'b1;
         end else begin
            unterm_s = unterm_s;
         end
         nxt_state_s = ST_CODE;
      end else begin
         nxt_state_s = nxt_state_s;
      end
   end

   // next-state for the output register, FSM and line counter
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      err_unterm_d = 1'b0;
      line_d       = line_q;
      if (flush_s) begin
         state_d     = ST_CODE;
         out_valid_d = 1'b1;
         out_data_d  = CH_SLASH;
         out_last_d  = 1'b0;
      end else if (xfer_s) begin
         state_d = nxt_state_s;
         if (emit_s) begin
            out_valid_d  = 1'b1;
            out_data_d   = emit_byte_s;
            out_last_d   = in_last;
            err_unterm_d = unterm_s;
         end else begin
            out_valid_d = 1'b0;
         end
         if (in_last)                 line_d = 16'd1;
         else if (in_data == CH_NL)   line_d = line_q + 16'd1;
         else                         line_d = line_q;
      end else begin
         state_d = state_q;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_CODE;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'h00;
         out_last_q   <= 1'b0;
         err_unterm_q <= 1'b0;
         line_q       <= 16'd1;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         err_unterm_q <= err_unterm_d;
         line_q       <= line_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign err_unterm = err_unterm_q;
   assign line_num   = line_q;

endmodule

// File: tb/tb_vlog_comment_strip.sv
// Bench for vlog_comment_strip: directed vector table, hand sequences and random files
// checked against a lookahead-based reference stripper.
module tb_vlog_comment_strip;

   localparam logic [7:0] CH_SL  = 8'h2F;
   localparam logic [7:0] CH_ST  = 8'h2A;
   localparam logic [7:0] CH_DQ  = 8'h22;
   localparam logic [7:0] CH_BS  = 8'h5C;
   localparam logic [7:0] CH_NL  = 8'h0A;
   localparam logic [7:0] CH_SP  = 8'h20;
   localparam logic [7:0] CH_TAB = 8'h09;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_FF  = 8'h0C;

   logic        clk, reset, in_valid, in_ready, in_last;
   logic        out_valid, out_ready, out_last, err_unterm;
   logic [7:0]  in_data, out_data;
   logic [15:0] line_num;

   typedef struct {
      string src;
      string exp;
      int    errs;
   } vec_t;

   vec_t        vq[$];
   logic [7:0]  src_q[$];
   logic [7:0]  exp_q[$];
   logic [8:0]  got[$];
   int          exp_err;
   int          err_seen;
   int          checks;
   int          errors;
   int          stall_total;
   int          rdy_mode;
   bit          hold_v;
   logic [8:0]  hold_d;

   vlog_comment_strip dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .err_unterm(err_unterm), .line_num(line_num)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // downstream readiness pattern
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else                    out_ready = 1'b0;
   end

   // output collector and backpressure stability monitor
   always @(negedge clk) begin
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            checks++;
            if (out_valid !== 1'b1 || {out_last, out_data} !== hold_d) begin
               errors++;
               $display("FAIL hold_stable: got v=%0b %h want v=1 %h", out_valid, {out_last, out_data}, hold_d);
            end
         end
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL in_ready_backpressure: got %0b want 0", in_ready);
            end
         end
         if (out_valid && out_ready) got.push_back({out_last, out_data});
         if (err_unterm) err_seen++;
         hold_v = out_valid && !out_ready;
         hold_d = {out_last, out_data};
      end
   end

   function automatic bit is_ws(input logic [7:0] c);
      return (c == CH_SP) || (c == CH_TAB) || (c == CH_NL) || (c == CH_CR) || (c == CH_FF);
   endfunction

   function automatic string chs(input logic [7:0] c);
      string s;
      s = " ";
      s.putc(0, c);
      return s;
   endfunction

   // reference stripper: scans the whole file with lookahead
   function automatic void run_model();
      int n; int i; int j; bit closed; logic [7:0] c;
      n = src_q.size(); i = 0; exp_q.delete(); exp_err = 0;
      while (i < n) begin
         c = src_q[i];
         if (c == CH_SL) begin
            if (i == n - 1) begin
               exp_q.push_back(CH_SL); i = i + 1;
            end else if (src_q[i+1] == CH_SL) begin
               j = i + 2;
               while (j < n && src_q[j] != CH_NL) j++;
               exp_q.push_back(CH_NL); i = j + 1;
            end else if (src_q[i+1] == CH_ST) begin
               exp_q.push_back(CH_SP);
               j = i + 2; closed = 1'b0;
               while (j < n && !closed) begin
                  if (src_q[j] == CH_ST && j + 1 < n && src_q[j+1] == CH_SL) begin
                     closed = 1'b1; j = j + 2;
                     if (j == n) exp_q.push_back(CH_NL);
                  end else begin
                     if (src_q[j] == CH_NL) exp_q.push_back(CH_NL);
                     j++;
                  end
               end
               if (!closed && i + 2 < n) begin
                  if (src_q[n-1] != CH_NL) exp_q.push_back(CH_NL);
                  exp_err++;
               end
               i = j;
            end else begin
               exp_q.push_back(CH_SL); i = i + 1;
            end
         end else if (c == CH_DQ) begin
            exp_q.push_back(c); i++;
            while (i < n) begin
               c = src_q[i]; exp_q.push_back(c); i++;
               if (c == CH_BS) begin
                  if (i < n) begin exp_q.push_back(src_q[i]); i++; end
               end else if (c == CH_DQ) begin
                  break;
               end else if (c == CH_NL) begin
                  exp_err++; break;
               end
            end
         end else if (c == CH_BS) begin
            exp_q.push_back(c); i++;
            while (i < n) begin
               c = src_q[i]; exp_q.push_back(c); i++;
               if (is_ws(c)) break;
            end
         end else begin
            exp_q.push_back(c); i++;
         end
      end
   endfunction

   function automatic void load_src(input string s);
      src_q.delete();
      for (int k = 0; k < s.len(); k++) src_q.push_back(s[k]);
   endfunction

   function automatic void load_exp(input string s, input int e);
      exp_q.delete();
      for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
      exp_err = e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic l);
      bit done;
      in_valid = 1'b1; in_data = b; in_last = l; done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else          stall_total++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL drive_timeout: byte %h never accepted", b);
      end
   endtask

   task automatic send_range(input int lo, input int hi, input bit last_at_end);
      for (int k = lo; k <= hi; k++) drive_byte(src_q[k], last_at_end && (k == hi));
   endtask

   task automatic finish_and_compare(input string name);
      int bad; logic [8:0] e9; int k;
      k = 0;
      while (k < 800 && !(got.size() > 0 && got[got.size()-1][8])) begin
         @(posedge clk); #1; k++;
      end
      repeat (3) begin @(posedge clk); #1; end
      bad = -1;
      for (int m = 0; m < exp_q.size() && m < got.size(); m++) begin
         e9 = {(m == exp_q.size() - 1), exp_q[m]};
         if (got[m] !== e9 && bad < 0) bad = m;
      end
      checks++;
      if (got.size() != exp_q.size() || bad >= 0) begin
         errors++;
         if (bad >= 0)
            $display("FAIL %s_stream: byte %0d got %h want %h (got %0d bytes want %0d)",
                     name, bad, got[bad], {(bad == exp_q.size() - 1), exp_q[bad]}, got.size(), exp_q.size());
         else
            $display("FAIL %s_stream: got %0d bytes want %0d", name, got.size(), exp_q.size());
      end
      chk({name, "_err_unterm"}, err_seen, exp_err);
      chk({name, "_line_num"}, int'(line_num), 1);
   endtask

   task automatic start_file();
      got.delete(); err_seen = 0; stall_total = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      vec_t v;
      string s_nl;
      string s_dq;
      string s_bs;
      s_nl = chs(CH_NL);
      s_dq = chs(CH_DQ);
      s_bs = chs(CH_BS);
      checks = 0; errors = 0; rdy_mode = 0; out_ready = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; hold_v = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_out_last", int'(out_last), 0);
      chk("reset_err_unterm", int'(err_unterm), 0);
      chk("reset_line_num", int'(line_num), 1);
      chk("reset_in_ready", int'(in_ready), 1);

      v.src = "a//x\nb";                      v.exp = "a\nb";                      v.errs = 0; vq.push_back(v);
      v.src = "'h2:/*c*/t=6;";                v.exp = "'h2: t=6;";                 v.errs = 0; vq.push_back(v);
      v.src = "'h0://E\nt";                   v.exp = "'h0:\nt";                   v.errs = 0; vq.push_back(v);
      v.src = {"(.CLK(C),/*", s_nl, ".IN(x),", s_nl, "*/.TC())"};
      v.exp = "(.CLK(C), \n\n.TC())";         v.errs = 0; vq.push_back(v);
      v.src = {"$display(", s_dq, "a//b", s_dq, ")"};
      v.exp = {"$display(", s_dq, "a//b", s_dq, ")"};
      v.errs = 0; vq.push_back(v);
      v.src = {s_bs, "a//b =1"};              v.exp = {s_bs, "a//b =1"};           v.errs = 0; vq.push_back(v);
      v.src = "x/y";                          v.exp = "x/y";                       v.errs = 0; vq.push_back(v);
      v.src = "p/*ab";                        v.exp = "p \n";                      v.errs = 1; vq.push_back(v);
      v.src = "s=\"ab\ncd";                   v.exp = "s=\"ab\ncd";                v.errs = 1; vq.push_back(v);
      v.src = "a/*x*/";                       v.exp = "a \n";                      v.errs = 0; vq.push_back(v);
      v.src = "q//";                          v.exp = "q\n";                       v.errs = 0; vq.push_back(v);
      v.src = "/";                            v.exp = "/";                         v.errs = 0; vq.push_back(v);
      v.src = "a/*/b*/c";                     v.exp = "a c";                       v.errs = 0; vq.push_back(v);
      v.src = "k**/*x**/m";                   v.exp = "k** m";                     v.errs = 0; vq.push_back(v);
      v.src = "a/b/";                         v.exp = "a/b/";                      v.errs = 0; vq.push_back(v);
      v.src = "\"x\\\"y\"z";                  v.exp = "\"x\\\"y\"z";               v.errs = 0; vq.push_back(v);
      v.src = "/*";                           v.exp = " ";                         v.errs = 0; vq.push_back(v);
      v.src = "u/*\n*";                       v.exp = "u \n\n";                    v.errs = 1; vq.push_back(v);

      foreach (vq[i]) begin
         load_src(vq[i].src);
         load_exp(vq[i].exp, vq[i].errs);
         start_file();
         send_range(0, src_q.size() - 1, 1'b1);
         finish_and_compare($sformatf("vec%0d", i));
      end

      // lone slash costs exactly one stall cycle
      load_src("x/y"); load_exp("x/y", 0); start_file();
      send_range(0, 2, 1'b1);
      chk("slash_stall_cycles", stall_total, 1);
      finish_and_compare("slash_flush");

      // five-cycle downstream stall in the middle of a file
      load_src({"ab/c", s_dq, "d//e", s_dq, "f//g", s_nl, "h"}); run_model(); start_file();
      fork
         send_range(0, src_q.size() - 1, 1'b1);
         begin
            repeat (2) @(posedge clk);
            rdy_mode = 2;
            repeat (5) @(posedge clk);
            rdy_mode = 0;
         end
      join
      finish_and_compare("hold5");

      // line counting across a multi-line block comment
      load_src({"ab", s_nl, "cd", s_nl, "/*", s_nl, ".", s_nl, "*/z"}); run_model(); start_file();
      send_range(0, 5, 1'b0);
      chk("line_after_two_nl", int'(line_num), 3);
      send_range(6, 12, 1'b0);
      chk("line_after_block", int'(line_num), 5);
      send_range(13, 13, 1'b1);
      finish_and_compare("line_count");

      // reset while inside a block comment discards the context
      load_src("/*ab"); start_file();
      send_range(0, 3, 1'b0);
      do_reset();
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_line_num", int'(line_num), 1);
      load_src("cd"); load_exp("cd", 0); start_file();
      send_range(0, 1, 1'b1);
      finish_and_compare("midreset");

      // random files under random backpressure
      rdy_mode = 1;
      for (int f = 0; f < 80; f++) begin
         int n; int r; logic [7:0] c;
         n = $urandom_range(1, 40);
         src_q.delete();
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 11);
            case (r)
               0, 1:    c = CH_SL;
               2:       c = CH_ST;
               3:       c = CH_DQ;
               4:       c = CH_BS;
               5:       c = CH_NL;
               6:       c = CH_SP;
               7:       c = CH_TAB;
               8:       c = 8'h61;
               9:       c = 8'h62;
               10:      c = 8'h3A;
               default: c = 8'h3B;
            endcase
            src_q.push_back(c);
         end
         run_model(); start_file();
         send_range(0, n - 1, 1'b1);
         finish_and_compare($sformatf("rand%0d", f));
      end
      rdy_mode = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vlog_comment_strip.md
# vlog_comment_strip

Byte-stream preprocessor that removes Verilog `//` line comments and `/* */` block comments from source text while preserving line structure. It sits directly upstream of the tokenizer, so the tokenizer never sees comment text. It handles the cases that break naive strippers: a comment directly after `:`, comments inside port lists, `//` inside string literals, and `//` inside escaped identifiers. It has a valid/ready handshake on both sides and is a single-stage registered pipeline.

## Interface
- No parameters.
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts the input byte this cycle.
- in_data  input  8  source byte (ASCII).
- in_last  input  1  final byte of the file.
- out_valid  output  1  out_data/out_last valid.
- out_ready  input  1  downstream accepts the output byte.
- out_data  output  8  stripped byte.
- out_last  output  1  final output byte of the file.
- err_unterm  output  1  one-cycle pulse on an unterminated block comment or string.
- line_num  output  16  current input line, 1-based.

## Operation
- Output register: out_valid/out_data/out_last are registered.
  - Base readiness: in_ready = !out_valid || out_ready.
  - in_ready is forced to 0 in the SLASH-flush cycle (below).
- A transfer occurs when in_valid && in_ready. A byte is consumed only on a transfer.
- States: CODE, SLASH, LINE, BLK, BLK_STAR, STR, STR_ESC, ESC_ID.
- CODE:
  - `/` → SLASH, no output.
  - `"` → STR, emit.
  - `\` → ESC_ID, emit.
  - Any other byte → emit.
- SLASH:
  - `/` → LINE, no output.
  - `*` → BLK, emit 0x20 (one space).
  - Any other byte: emit `/` **without consuming** the byte (in_ready=0), → CODE. The held byte is reprocessed in CODE next cycle. This path always costs one extra cycle.
- LINE:
  - `\n` → CODE, emit `\n`.
  - Any other byte: drop.
- BLK:
  - `*` → BLK_STAR.
  - `\n` → emit `\n` (preserves line numbers).
  - Any other byte: drop.
- BLK_STAR:
  - `/` → CODE, no output.
  - `*` → stay in BLK_STAR.
  - `\n` → emit, → BLK.
  - Any other byte → BLK.
  - Block comments do not nest; `/*/` does not close.
- STR:
  - `\` → STR_ESC, emit.
  - `"` → CODE, emit.
  - `\n` → CODE, emit, pulse err_unterm.
  - Any other byte: emit.
- STR_ESC: any byte → STR, emit.
- ESC_ID: emit all bytes. Space, tab, `\n`, `\r`, or 0x0C → emit, → CODE.
- in_last handling:
  - If the last byte produces an emission, that emission carries out_last=1.
  - `/` with in_last in CODE: emit `/` with out_last=1.
  - Last byte dropped (LINE, BLK, BLK_STAR, or `/` arriving in SLASH that opens a comment): emit `\n` with out_last=1.
  - Last byte in SLASH that is neither `/` nor `*`: the flush `/` is emitted normally, then the byte is reprocessed carrying in_last.
  - Last byte consumed in BLK or BLK_STAR without closing the comment: also pulse err_unterm.
  - After any in_last transfer the state returns to CODE and line_num returns to 1.
- line_num increments on each consumed `\n`. It wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: out_valid=0, out_data=0x00, out_last=0, err_unterm=0, line_num=1, state=CODE.
- Reset mid-file drops any pending `/` and comment/string context.
- Latency: one cycle from the input transfer to out_valid. Throughput: one byte/cycle, except the SLASH flush, which costs one extra cycle.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- err_unterm is asserted in the same cycle that the offending output byte becomes valid (registered alongside it).
- Dropped bytes consume a cycle but leave out_valid low unless a prior byte is still held.

## Test plan
- Line comment: `a//x\nb` with last on `b` → `a\nb`, out_last on `b`, line_num ends at 1 after reset-on-last.
- Comment after colon: `'h2:/*c*/t=6;` → `'h2: t=6;`; `'h0://E\nt` → `'h0:\nt`.
- Multi-line block comment: `(.CLK(C),/*\n.IN(x),\n*/.TC())` → `(.CLK(C), \n\n.TC())`, with 2 newlines emitted; line_num advances 3→... by 2.
- String and escaped identifier: `$display("a//b")` and `\a//b =1` both pass byte-exact.
- Lone slash with backpressure:
  - Input `x/y`: in_ready drops for exactly 1 cycle at `y`, output `x/y`.
  - Hold out_ready=0 for 5 cycles mid-stream: no byte lost or duplicated.
- Unterminated block comment: `p/*ab` with last on `b` → output `p`, ` `, `\n` (out_last=1), and a single err_unterm pulse.
- Reset mid-comment: after `/*ab`, assert reset 1 cycle, then send `cd` → `cd`.
